chnl_rr_sched: RTL and testbench
================================

// Module: chnl_rr_sched
// PURPOSE
//  Priority plus round-robin scheduler between the slave channels and the formatter.
//  Grants one channel per package and holds the grant for exactly the package's beat count.
//  Routes the formatter ack back to that channel only, then rotates the tie-break pointer.
//  Ties on equal priority therefore no longer always favour the lowest channel.
// PARAMETERS
//  NCH     3   number of slave channels (2..3; the id space is 2 bits, 2'b11 = no grant)
//  DW      32  data width
//  PRIO_W  2   priority field width; a lower value means a higher priority
//  LEN_W   3   package-length select width
// PORTS
//  clk_i           in   1           clock
//  rst_i           in   1           synchronous, active-high reset
//  slv_prio_i      in   NCH*PRIO_W  per-channel priority, from the registers
//  slv_pkglen_i    in   NCH*LEN_W   per-channel package-length select, from the registers
//  slv_req_i       in   NCH         channel has a package pending
//  slv_val_i       in   NCH         channel data valid
//  slv_data_i      in   NCH*DW      channel data, channel n at [n*DW +: DW]
//  a2s_ack_o       out  NCH         per-channel beat acknowledge
//  f2a_id_req_i    in   1           formatter ready to accept a new package
//  f2a_ack_i       in   1           formatter accepts the current beat
//  a2f_val_o       out  1           data valid toward the formatter
//  a2f_id_o        out  2           granted channel id; 2'b11 when there is no grant
//  a2f_data_o      out  DW          granted channel data; all ones when there is no grant
//  a2f_pkglen_sel_o out LEN_W       pkglen select latched for the current package
// BEHAVIOUR
//  Reset (rst_i=1 at clk_i edge):
//   - state=IDLE, ptr=0, cnt=0
//   - a2f_id_o=2'b11, a2f_data_o=all ones, a2f_val_o=0, a2s_ack_o=0, a2f_pkglen_sel_o=0
//   - Reset in mid-burst aborts the burst; the package is not resumed.
//  Beat count: beats = 4 << pkglen for pkglen 0..3 (4/8/16/32); codes 4..7 give 32.
//  FSM, registered state:
//   IDLE -> GRANT when f2a_id_req_i=1 and |slv_req_i at the same edge.
//    - Winner: the lowest prio value among requesters.
//    - Ties: the first tied channel at or after ptr, scanning upward modulo NCH.
//    - On that edge: latch gnt_id and the winner's pkglen; clear cnt.
//    - No request means stay in IDLE and keep the outputs at their idle values.
//   GRANT: a beat is a cycle with slv_val_i[gnt]=1 and f2a_ack_i=1.
//    - Each beat increments cnt.
//    - On the beat where cnt==beats-1: go to IDLE and set ptr=(gnt_id+1) mod NCH.
//  Grant latency: a2f_id_o changes 1 cycle after the qualifying f2a_id_req_i edge.
//  Datapath outputs are combinational from gnt_id in GRANT:
//   - a2f_val_o = slv_val_i[gnt]
//   - a2f_data_o = slv_data_i[gnt]
//   - a2s_ack_o[gnt] = f2a_ack_i; all other ack bits are 0
//  In IDLE: a2s_ack_o=0 and a2f_val_o=0 regardless of f2a_ack_i.
//  Boundary conditions:
//   - f2a_id_req_i during GRANT is ignored; the grant is never pre-empted.
//   - Register prio/pkglen changes during GRANT do not affect the current package.
//   - The granted channel dropping slv_req_i mid-burst does not end the grant;
//     the burst completes on beat count only.
//   - Beats with val=1 and ack=0 or val=0 and ack=1 do not count.
//   - The last beat and an f2a_id_req_i on the same edge: the new arbitration
//     happens at the next IDLE edge. Minimum 1 IDLE cycle between packages.
//   - cnt is 5 bits and holds at most 31; it never wraps inside a package.
// STRUCTURE
//  chnl_pkg holds:
//   - NCH, ID_NONE=2'b11, the state enum {IDLE,GRANT}
//   - function pkglen2beats(LEN_W) -> 6-bit
//  Sub-module rr_prio_pick (combinational) takes req, prio, ptr and returns a
//  one-hot winner plus its id and a valid flag. The FSM, counter and mux live in the top.
// TESTING
//  1. Only ch1 requests, prio 2, pkglen 0; f2a_id_req pulse
//     -> a2f_id=01 next cycle; 4 acked beats; then id=11 and ptr=2.
//  2. All 3 channels request; prio ch0=2, ch1=0, ch2=1
//     -> ch1 granted; after its package ch2 wins over ch0 by priority.
//  3. All prio=1 and requesting continuously, pkglen 0
//     -> grant order 0,1,2,0 across successive f2a_id_req pulses.
//  4. ch0 granted with pkglen 1; val toggles and ack held low on odd cycles
//     -> exactly 8 val&ack beats before IDLE; ch1/ch2 acks stay 0 throughout.
//  5. rst_i=1 asserted at beat 5 of a 16-beat package
//     -> next cycle id=11, val=0, ack=0; after release ptr=0 and ch0 wins a tie.
//  6. pkglen=7 on ch2 and pkglen changed to 0 mid-package
//     -> a2f_pkglen_sel_o stays 7; exactly 32 beats are counted.

Source files
------------

// File: rtl/chnl_rr_sched_pkg.sv
// Shared types and helpers for the channel priority/round-robin scheduler.
package chnl_pkg;

  localparam int NCH   = 3;
  localparam int LEN_W = 3;
  localparam logic [1:0] ID_NONE = 2'b11;

  typedef enum logic {IDLE, GRANT} state_e;

  // Codes above 3 saturate at the longest package.
  function automatic logic [5:0] pkglen2beats(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(3)) return 6'd32;
    return 6'd4 << len[1:0];
  endfunction

endpackage

// File: rtl/chnl_rr_sched_if.sv
// Scheduler bus: slave-channel side inputs, formatter handshake, per-channel acks.
interface chnl_rr_sched_if #(
  parameter int NCH    = 3,
  parameter int DW     = 32,
  parameter int PRIO_W = 2,
  parameter int LEN_W  = 3
);
  logic [NCH*PRIO_W-1:0] slv_prio_i;
  logic [NCH*LEN_W-1:0]  slv_pkglen_i;
  logic [NCH-1:0]        slv_req_i;
  logic [NCH-1:0]        slv_val_i;
  logic [NCH*DW-1:0]     slv_data_i;
  logic [NCH-1:0]        a2s_ack_o;
  logic                  f2a_id_req_i;
  logic                  f2a_ack_i;
  logic                  a2f_val_o;
  logic [1:0]            a2f_id_o;
  logic [DW-1:0]         a2f_data_o;
  logic [LEN_W-1:0]      a2f_pkglen_sel_o;

  modport master (
    input  slv_prio_i, slv_pkglen_i, slv_req_i, slv_val_i, slv_data_i,
    input  f2a_id_req_i, f2a_ack_i,
    output a2s_ack_o, a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o
  );

  modport slave (
    output slv_prio_i, slv_pkglen_i, slv_req_i, slv_val_i, slv_data_i,
    output f2a_id_req_i, f2a_ack_i,
    input  a2s_ack_o, a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o
  );
endinterface

// File: rtl/chnl_rr_sched_rr_prio_pick.sv
// Combinational winner selection: lowest priority value, ties broken from ptr upward.
module rr_prio_pick #(
  parameter int NCH    = 3,
  parameter int PRIO_W = 2
) (
  input  logic [NCH-1:0]        req,
  input  logic [NCH*PRIO_W-1:0] prio,
  input  logic [1:0]            ptr,
  output logic [NCH-1:0]        gnt_oh,
  output logic [1:0]            gnt_id,
  output logic                  gnt_vld
);
  import chnl_pkg::*;

  logic [PRIO_W-1:0] min_p;
  logic              any_req;
  logic              done;

  always_comb begin
    int idx;
    min_p   = '1;
    any_req = 1'b0;
    gnt_oh  = '0;
    gnt_id  = ID_NONE;
    done    = 1'b0;
    idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      if (req[i] && (!any_req || prio[i*PRIO_W +: PRIO_W] < min_p)) begin
        min_p   = prio[i*PRIO_W +: PRIO_W];
        any_req = 1'b1;
      end
    end
    // Second pass walks the channels starting at ptr so equal priorities rotate.
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!done && req[idx] && prio[idx*PRIO_W +: PRIO_W] == min_p) begin
        gnt_oh[idx] = 1'b1;
        gnt_id      = 2'(idx);
        done        = 1'b1;
      end
    end
    gnt_vld = any_req;
  end

endmodule

// File: rtl/chnl_rr_sched.sv
// Priority + round-robin scheduler: one channel per package, held for its beat count.
module chnl_rr_sched #(
  parameter int NCH    = chnl_pkg::NCH,
  parameter int DW     = 32,
  parameter int PRIO_W = 2,
  parameter int LEN_W  = chnl_pkg::LEN_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  chnl_rr_sched_if.master bus
);
  import chnl_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] pkglen_q, pkglen_d;

  logic [NCH-1:0]   pick_oh;
  logic [1:0]       pick_id;
  logic             pick_vld;
  logic [LEN_W-1:0] win_len;
  logic             sel_val;
  logic [DW-1:0]    sel_data;
  logic [5:0]       beats_m1;
  logic             beat;
  logic             last;

  rr_prio_pick #(.NCH(NCH), .PRIO_W(PRIO_W)) u_pick (
    .req     (bus.slv_req_i),
    .prio    (bus.slv_prio_i),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

  always_comb begin
    win_len  = '0;
    sel_val  = 1'b0;
    sel_data = '1;
    for (int i = 0; i < NCH; i++) begin
      if (pick_oh[i]) win_len = bus.slv_pkglen_i[i*LEN_W +: LEN_W];
      if (gnt_id_q == 2'(i)) begin
        sel_val  = bus.slv_val_i[i];
        sel_data = bus.slv_data_i[i*DW +: DW];
      end
    end
  end

  assign beats_m1 = pkglen2beats(pkglen_q) - 6'd1;
  assign beat     = (state_q == GRANT) && sel_val && bus.f2a_ack_i;
  assign last     = beat && ({1'b0, cnt_q} == beats_m1);

  always_comb begin
    state_d              = state_q;
    ptr_d                = ptr_q;
    gnt_id_d             = gnt_id_q;
    cnt_d                = cnt_q;
    pkglen_d             = pkglen_q;
    bus.a2f_id_o         = ID_NONE;
    bus.a2f_val_o        = 1'b0;
    bus.a2f_data_o       = '1;
    bus.a2s_ack_o        = '0;
    bus.a2f_pkglen_sel_o = pkglen_q;
    case (state_q)
      IDLE: begin
        if (bus.f2a_id_req_i && pick_vld) begin
          state_d  = GRANT;
          gnt_id_d = pick_id;
          pkglen_d = win_len;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        bus.a2f_id_o   = gnt_id_q;
        bus.a2f_val_o  = sel_val;
        bus.a2f_data_o = sel_data;
        for (int i = 0; i < NCH; i++)
          bus.a2s_ack_o[i] = (gnt_id_q == 2'(i)) && bus.f2a_ack_i;
        if (beat) begin
          cnt_d = cnt_q + 5'd1;
          // Last beat returns to IDLE; new arbitration waits for the next edge.
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = (gnt_id_q == 2'(NCH-1)) ? 2'd0 : gnt_id_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= ID_NONE;
      cnt_q    <= '0;
      pkglen_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      cnt_q    <= cnt_d;
      pkglen_q <= pkglen_d;
    end
  end

endmodule

// File: tb/tb_chnl_rr_sched.sv
// Scenario bench for chnl_rr_sched: grant order, beat counting, reset abort, pkglen latch.
module tb_chnl_rr_sched;
  localparam int NCH = 3, DW = 32, PRIO_W = 2, LEN_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chnl_rr_sched_if #(.NCH(NCH), .DW(DW), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) bus ();
  chnl_rr_sched #(.NCH(NCH), .DW(DW), .PRIO_W(PRIO_W), .LEN_W(LEN_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [1:0] exp_q[$];

  function automatic logic [DW-1:0] mk(input int ch, input int k);
    return 32'hA000_0000 | (32'(ch) << 24) | 32'(k);
  endfunction

  task automatic drive_data(input int k);
    for (int c = 0; c < NCH; c++) bus.slv_data_i[c*DW +: DW] = mk(c, k);
  endtask

  task automatic set_ch(input int ch, input logic [PRIO_W-1:0] p, input logic [LEN_W-1:0] l);
    bus.slv_prio_i[ch*PRIO_W +: PRIO_W] = p;
    bus.slv_pkglen_i[ch*LEN_W +: LEN_W] = l;
  endtask

  // Pulse f2a_id_req for one edge; the grant id is expected at the next sample.
  task automatic arb(input logic [1:0] exp);
    logic [1:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.f2a_id_req_i = 1'b1;
    bus.f2a_ack_i    = 1'b0;
    #1;
    chk_cnt++;
    if (bus.a2f_id_o !== 2'b11) $display("FAIL pre_grant_id: got %b want 11", bus.a2f_id_o);
    else pass_cnt++;
    @(negedge clk);
    bus.f2a_id_req_i = 1'b0;
    #1;
    want = exp_q.pop_front();
    chk_cnt++;
    if (bus.a2f_id_o !== want) $display("FAIL grant_id: got %b want %b", bus.a2f_id_o, want);
    else pass_cnt++;
  endtask

  // mode 0: val=ack=1 every cycle; mode 1: val and ack interleaved so some cycles do not count.
  task automatic burst(input logic [1:0] gnt, input int n, input logic [LEN_W-1:0] exp_len,
                       input int mode, input bit hold_req);
    int beats;
    int k;
    logic v, a;
    logic [NCH-1:0] exp_ack;
    beats = 0;
    k = 0;
    while (beats < n && k < 400) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : ((k % 3) != 2);
      a = (mode == 0) ? 1'b1 : ((k % 2) == 0);
      bus.slv_val_i    = v ? '1 : '0;
      bus.f2a_ack_i    = a;
      bus.f2a_id_req_i = hold_req;
      drive_data(k);
      #1;
      exp_ack = '0;
      if (a) exp_ack[gnt] = 1'b1;
      chk_cnt++;
      if (bus.a2f_id_o !== gnt) $display("FAIL burst_id: beat %0d got %b want %b", beats, bus.a2f_id_o, gnt);
      else pass_cnt++;
      chk_cnt++;
      if (bus.a2f_val_o !== v) $display("FAIL burst_val: got %b want %b", bus.a2f_val_o, v);
      else pass_cnt++;
      chk_cnt++;
      if (bus.a2f_data_o !== mk(gnt, k)) $display("FAIL burst_data: got %h want %h", bus.a2f_data_o, mk(gnt, k));
      else pass_cnt++;
      chk_cnt++;
      if (bus.a2s_ack_o !== exp_ack) $display("FAIL burst_ack: got %b want %b", bus.a2s_ack_o, exp_ack);
      else pass_cnt++;
      chk_cnt++;
      if (bus.a2f_pkglen_sel_o !== exp_len) $display("FAIL burst_pkglen: got %0d want %0d", bus.a2f_pkglen_sel_o, exp_len);
      else pass_cnt++;
      if (v && a) beats++;
      k++;
    end
    chk_cnt++;
    if (beats < n) $display("FAIL burst_timeout: got %0d beats want %0d", beats, n);
    else pass_cnt++;
    @(negedge clk);
    bus.f2a_id_req_i = 1'b0;
    bus.slv_val_i    = '1;
    bus.f2a_ack_i    = 1'b1;
    #1;
    chk_cnt++;
    if (bus.a2f_id_o !== 2'b11) $display("FAIL end_id: got %b want 11", bus.a2f_id_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.a2f_val_o !== 1'b0 || bus.a2s_ack_o !== '0)
      $display("FAIL end_idle_hs: got val %b ack %b want 0 000", bus.a2f_val_o, bus.a2s_ack_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.a2f_data_o !== '1) $display("FAIL end_data: got %h want ffffffff", bus.a2f_data_o);
    else pass_cnt++;
    bus.f2a_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.slv_req_i = '0;
    bus.slv_val_i = '1;
    bus.f2a_ack_i = 1'b1;
    bus.f2a_id_req_i = 1'b0;
    drive_data(0);
    for (int c = 0; c < NCH; c++) set_ch(c, 2'd2, 3'd0);
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++;
    if (bus.a2f_id_o !== 2'b11) $display("FAIL rst_id: got %b want 11", bus.a2f_id_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.a2f_data_o !== '1) $display("FAIL rst_data: got %h want ffffffff", bus.a2f_data_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.a2f_val_o !== 1'b0 || bus.a2s_ack_o !== '0)
      $display("FAIL rst_hs: got val %b ack %b want 0 000", bus.a2f_val_o, bus.a2s_ack_o);
    else pass_cnt++;
    chk_cnt++;
    if (bus.a2f_pkglen_sel_o !== '0) $display("FAIL rst_pkglen: got %0d want 0", bus.a2f_pkglen_sel_o);
    else pass_cnt++;
    rst = 1'b0;
    bus.f2a_ack_i = 1'b0;
    // id request with nobody pending must leave the scheduler idle
    @(negedge clk); bus.f2a_id_req_i = 1'b1;
    @(negedge clk); bus.f2a_id_req_i = 1'b0; #1;
    chk_cnt++;
    if (bus.a2f_id_o !== 2'b11) $display("FAIL noreq_id: got %b want 11", bus.a2f_id_o);
    else pass_cnt++;
  endtask

  task automatic test_single();
    bus.slv_req_i = 3'b010;
    set_ch(1, 2'd2, 3'd0);
    arb(2'd1);
    burst(2'd1, 4, 3'd0, 0, 1'b0);
    // ptr is now 2: a ch0/ch2 tie must go to ch2
    bus.slv_req_i = 3'b101;
    arb(2'd2);
    burst(2'd2, 4, 3'd0, 0, 1'b0);
  endtask

  task automatic test_priority();
    set_ch(0, 2'd2, 3'd0);
    set_ch(1, 2'd0, 3'd0);
    set_ch(2, 2'd1, 3'd0);
    bus.slv_req_i = 3'b111;
    arb(2'd1);
    burst(2'd1, 4, 3'd0, 0, 1'b0);
    bus.slv_req_i = 3'b101;
    arb(2'd2);
    burst(2'd2, 4, 3'd0, 0, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    order = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int c = 0; c < NCH; c++) set_ch(c, 2'd1, 3'd0);
    bus.slv_req_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      arb(order[i]);
      burst(order[i], 4, 3'd0, 0, 1'b1);
    end
  endtask

  task automatic test_gaps();
    set_ch(0, 2'd1, 3'd1);
    bus.slv_req_i = 3'b001;
    arb(2'd0);
    bus.slv_req_i = 3'b000;
    burst(2'd0, 8, 3'd1, 1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    set_ch(0, 2'd1, 3'd2);
    bus.slv_req_i = 3'b001;
    arb(2'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.slv_val_i = '1;
      bus.f2a_ack_i = 1'b1;
      drive_data(k);
      #1;
      chk_cnt++;
      if (bus.a2f_id_o !== 2'd0) $display("FAIL abort_pre_id: got %b want 00", bus.a2f_id_o);
      else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (bus.a2f_id_o !== 2'b11 || bus.a2f_val_o !== 1'b0 || bus.a2s_ack_o !== '0)
      $display("FAIL abort_idle: got id %b val %b ack %b want 11 0 000",
               bus.a2f_id_o, bus.a2f_val_o, bus.a2s_ack_o);
    else pass_cnt++;
    rst = 1'b0;
    bus.f2a_ack_i = 1'b0;
    for (int c = 0; c < NCH; c++) set_ch(c, 2'd1, 3'd0);
    bus.slv_req_i = 3'b111;
    arb(2'd0);
    burst(2'd0, 4, 3'd0, 0, 1'b0);
  endtask

  task automatic test_pkglen_latch();
    set_ch(2, 2'd3, 3'd7);
    bus.slv_req_i = 3'b100;
    arb(2'd2);
    // Register changes and competing requests while granted must not matter
    set_ch(2, 2'd0, 3'd0);
    set_ch(0, 2'd0, 3'd0);
    bus.slv_req_i = 3'b001;
    burst(2'd2, 32, 3'd7, 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.slv_prio_i   = '0;
    bus.slv_pkglen_i = '0;
    bus.slv_req_i    = '0;
    bus.slv_val_i    = '0;
    bus.slv_data_i   = '0;
    bus.f2a_id_req_i = 1'b0;
    bus.f2a_ack_i    = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_gaps();
    test_reset_mid_burst();
    test_pkglen_latch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
